// File: rtl/div_ratio_ctrl_if.sv
// Ratio-change request channel of div_ratio_ctrl: valid/ready handshake plus reject pulse.
// master = configuration side, slave = controller side.
interface div_ratio_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             req_valid;
  logic [CNT_W-1:0] req_ratio;
  logic             req_ready;
  logic             err;

  modport master (
    output req_valid,
    output req_ratio,
    input  req_ready,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_ratio,
    output req_ready,
    output err
  );
endinterface

// File: rtl/div_ratio_ctrl.sv
// Run-time ratio controller and programmable clock divider; ratio switches only at period wrap.
// Optional macro ODD_HALF_EN: negedge flop stretches the high phase so odd ratios get exact 50% duty.
module div_ratio_ctrl #(
  parameter int CNT_W     = 7,
  parameter int DEF_RATIO = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  div_ratio_ctrl_if.slave  req,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             busy,
  output logic             period_tick,
  output logic             out,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cur_ratio_r;
  logic [CNT_W-1:0] pend_ratio_r;
  logic             pend_r;
  logic             hi_r;
  logic             tick_r;
  logic             err_r;
  logic             busy_r;

  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] ratio_next_s;
  logic             pend_next_s;
  logic             apply_s;
  logic             wrap_s;
  logic             acc_s;
  logic             acc_ok_s;
  logic             run_next_s;
  logic             hi_next_s;
  logic             tick_next_s;

  wire unused_pwr_s;
  assign unused_pwr_s = VDD ^ VSS;

  // Number of high cycles of the posedge phase for ratio n.
  function automatic logic [CNT_W:0] calc_half(input logic [CNT_W-1:0] n);
`ifdef ODD_HALF_EN
    return {1'b0, n} >> 1;
`else
    return ({1'b0, n} + (CNT_W+1)'(1)) >> 1;
`endif
  endfunction

  // Next-state, counter, pending-ratio and output decode.
  always_comb begin
    wrap_s       = (cnt_r == (cur_ratio_r - CNT_W'(1)));
    acc_s        = req.req_valid & ~pend_r;
    acc_ok_s     = acc_s & (req.req_ratio >= CNT_W'(2));
    apply_s      = 1'b0;
    cnt_next_s   = '0;
    state_next_s = state_r;
    case (state_r)
      ST_OFF: begin
        apply_s      = pend_r;
        cnt_next_s   = '0;
        state_next_s = en ? ST_RUN : ST_OFF;
      end
      ST_RUN, ST_SWITCH: begin
        if (wrap_s) begin
          apply_s      = pend_r;
          cnt_next_s   = '0;
          state_next_s = en ? ST_RUN : ST_OFF;
        end else begin
          apply_s      = 1'b0;
          cnt_next_s   = cnt_r + CNT_W'(1);
          state_next_s = ST_RUN;
        end
      end
      default: begin
        apply_s      = 1'b0;
        cnt_next_s   = '0;
        state_next_s = ST_OFF;
      end
    endcase
    pend_next_s = acc_ok_s | (pend_r & ~apply_s);
    // A request landing on the wrap edge must wait for the following wrap.
    if ((state_next_s == ST_RUN) && pend_next_s) begin
      state_next_s = ST_SWITCH;
    end else begin
      state_next_s = state_next_s;
    end
    ratio_next_s = apply_s ? pend_ratio_r : cur_ratio_r;
    run_next_s   = (state_next_s != ST_OFF);
    hi_next_s    = run_next_s & ({1'b0, cnt_next_s} < calc_half(ratio_next_s));
    tick_next_s  = run_next_s & (cnt_next_s == (ratio_next_s - CNT_W'(1)));
  end

  // FSM state, counter, ratio bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_OFF;
      cnt_r        <= '0;
      cur_ratio_r  <= CNT_W'(DEF_RATIO);
      pend_ratio_r <= '0;
      pend_r       <= 1'b0;
      hi_r         <= 1'b0;
      tick_r       <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      cur_ratio_r <= ratio_next_s;
      pend_r      <= pend_next_s;
      if (acc_ok_s) begin
        pend_ratio_r <= req.req_ratio;
      end else begin
        pend_ratio_r <= pend_ratio_r;
      end
      hi_r   <= hi_next_s;
      tick_r <= tick_next_s;
      err_r  <= acc_s & ~acc_ok_s;
      busy_r <= run_next_s;
    end
  end

`ifdef ODD_HALF_EN
  logic hi_neg_r;

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      hi_neg_r <= 1'b0;
    end else begin
      hi_neg_r <= hi_r & cur_ratio_r[0];
    end
  end

  assign out = hi_r | hi_neg_r;
`else
  assign out = hi_r;
`endif

  assign req.req_ready = reset & ~pend_r;
  assign req.err       = err_r;
  assign cur_ratio     = cur_ratio_r;
  assign busy          = busy_r;
  assign period_tick   = tick_r;

endmodule
